// File: rtl/mips_pkg.sv
// ISA encodings, ALU control and the control word for the single-cycle MIPS subset core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    typedef struct packed {
        logic    regwrite;
        logic    regdst;
        logic    alusrc;
        logic    memwrite;
        logic    memtoreg;
        logic    branch;
        logic    bne;
        logic    jump;
        logic    jal;
        logic    jr;
        logic    hilo;
        logic    mul_signed;
        logic    zeroext;
        logic    mfhi;
        logic    mflo;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_alu.sv
// 32-bit wrap-around ALU; shifts act on operand b by shamt, LUI places b[15:0] in the upper half.
module mips_alu
    import mips_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {31'h0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'h0, a < b};
            ALU_SLL:  y = b << shamt;
            ALU_SRL:  y = b >> shamt;
            ALU_SRA:  y = $unsigned($signed(b) >>> shamt);
            ALU_LUI:  y = {b[15:0], 16'h0};
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/mips_controller.sv
// Decodes opcode/funct into the control word; anything unlisted decodes to an all-zero (NOP) word.
module mips_controller
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);
    always_comb begin
        // NOTE: the whole word is defaulted first so no decode path leaves a field unassigned.
        ctrl = '0;
        ctrl.alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
                    FN_AND:   ctrl.alu_op = ALU_AND;
                    FN_OR:    ctrl.alu_op = ALU_OR;
                    FN_XOR:   ctrl.alu_op = ALU_XOR;
                    FN_NOR:   ctrl.alu_op = ALU_NOR;
                    FN_SLT:   ctrl.alu_op = ALU_SLT;
                    FN_SLTU:  ctrl.alu_op = ALU_SLTU;
                    FN_SLL:   ctrl.alu_op = ALU_SLL;
                    FN_SRL:   ctrl.alu_op = ALU_SRL;
                    FN_SRA:   ctrl.alu_op = ALU_SRA;
                    FN_MFHI:  ctrl.mfhi = 1'b1;
                    FN_MFLO:  ctrl.mflo = 1'b1;
                    FN_JR:    begin ctrl.regwrite = 1'b0; ctrl.jr = 1'b1; end
                    FN_MULT:  begin ctrl.regwrite = 1'b0; ctrl.hilo = 1'b1; ctrl.mul_signed = 1'b1; end
                    FN_MULTU: begin ctrl.regwrite = 1'b0; ctrl.hilo = 1'b1; end
                    default:  ctrl.regwrite = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; end
            OP_SLTI:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alu_op = ALU_SLT;  end
            OP_SLTIU: begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alu_op = ALU_SLTU; end
            OP_ANDI:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.zeroext = 1'b1; ctrl.alu_op = ALU_AND; end
            OP_ORI:   begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.zeroext = 1'b1; ctrl.alu_op = ALU_OR;  end
            OP_XORI:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.zeroext = 1'b1; ctrl.alu_op = ALU_XOR; end
            OP_LUI:   begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alu_op = ALU_LUI; end
            OP_LW:    begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.memtoreg = 1'b1; end
            OP_SW:    begin ctrl.alusrc = 1'b1; ctrl.memwrite = 1'b1; end
            OP_BEQ:   ctrl.branch = 1'b1;
            OP_BNE:   begin ctrl.branch = 1'b1; ctrl.bne = 1'b1; end
            OP_J:     ctrl.jump = 1'b1;
            OP_JAL:   begin ctrl.jump = 1'b1; ctrl.jal = 1'b1; ctrl.regwrite = 1'b1; end
            default:  ctrl.regwrite = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_core.sv
// Processor core: instruction decoder plus datapath.
module mips_core
    import mips_pkg::*;
#(
    parameter int          IMEM_WORDS = 64,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   instr,
    output logic [$clog2(IMEM_WORDS)-1:0] fetch_idx
);
    ctrl_t ctrl;

    mips_controller controller (.op(instr[31:26]), .funct(instr[5:0]), .ctrl(ctrl));

    mips_dp #(
        .IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS), .RESET_PC(RESET_PC)
    ) dp (
        .clk(clk), .reset(reset), .ctrl(ctrl), .instr_body(instr[25:0]), .fetch_idx(fetch_idx)
    );
endmodule

// File: rtl/mips_dp.sv
// Datapath: PC, HI/LO, register file, ALU, multiplier and data RAM; one instruction commits per edge.
module mips_dp
    import mips_pkg::*;
#(
    parameter int          IMEM_WORDS = 64,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  ctrl_t                         ctrl,
    input  logic [25:0]                   instr_body,
    output logic [$clog2(IMEM_WORDS)-1:0] fetch_idx
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] pc_q, pc_d, hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pc_plus4, sign_imm, src_a, src_b, rd2, alu_y, mem_rdata, wb_data;
    logic [63:0] mul_a, mul_b, product;
    logic [4:0]  wa;
    logic        taken, gpr_we, mem_we;
    logic [31:0] dmem [0:DMEM_WORDS-1];

    mips_gpr gpr (
        .clk(clk), .we(gpr_we), .ra1(instr_body[25:21]), .ra2(instr_body[20:16]),
        .wa(wa), .wd(wb_data), .rd1(src_a), .rd2(rd2)
    );

    mips_alu alu (
        .op(ctrl.alu_op), .a(src_a), .b(src_b), .shamt(instr_body[10:6]), .y(alu_y)
    );

    assign fetch_idx = pc_q[IAW+1:2];

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        sign_imm = {{16{instr_body[15]}}, instr_body[15:0]};
        src_b    = ctrl.alusrc ? (ctrl.zeroext ? {16'h0, instr_body[15:0]} : sign_imm) : rd2;
        taken    = ctrl.branch && ((src_a == rd2) != ctrl.bne);

        pc_d = pc_plus4;
        if (ctrl.jr)        pc_d = src_a;
        else if (ctrl.jump) pc_d = {pc_plus4[31:28], instr_body, 2'b00};
        else if (taken)     pc_d = pc_plus4 + {sign_imm[29:0], 2'b00};

        // Extending to 64 bits first makes one unsigned multiply serve both mult and multu.
        mul_a   = ctrl.mul_signed ? {{32{src_a[31]}}, src_a} : {32'h0, src_a};
        mul_b   = ctrl.mul_signed ? {{32{rd2[31]}}, rd2}     : {32'h0, rd2};
        product = mul_a * mul_b;
        hi_d    = ctrl.hilo ? product[63:32] : hi_q;
        lo_d    = ctrl.hilo ? product[31:0]  : lo_q;

        mem_rdata = dmem[alu_y[DAW+1:2]];
        wa        = ctrl.jal ? 5'd31 : (ctrl.regdst ? instr_body[15:11] : instr_body[20:16]);
        if (ctrl.jal)           wb_data = pc_plus4;
        else if (ctrl.mfhi)     wb_data = hi_q;
        else if (ctrl.mflo)     wb_data = lo_q;
        else if (ctrl.memtoreg) wb_data = mem_rdata;
        else                    wb_data = alu_y;

        gpr_we = ctrl.regwrite && !reset;
        mem_we = ctrl.memwrite && !reset;
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            pc_q <= pc_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) dmem[alu_y[DAW+1:2]] <= rd2;
    end
endmodule

// File: rtl/mips_gpr.sv
// 32x32 general-purpose register file: two combinational reads, one synchronous write, $0 hardwired.
module mips_gpr (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    // NOTE: storage arrays get no reset, so preloaded contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we && wa != 5'd0) registers[wa] <= wd;
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : registers[ra2];
endmodule

// File: rtl/mips_imem.sv
// Instruction ROM; contents are loaded from outside, fetch is combinational.
module mips_imem #(
    parameter int IMEM_WORDS = 64
) (
    input  logic [$clog2(IMEM_WORDS)-1:0] idx,
    output logic [31:0]                   instr
);
    logic [31:0] INSTRROM [0:IMEM_WORDS-1];

    assign instr = INSTRROM[idx];
endmodule

// File: rtl/mips_processor.sv
// Top level: instruction ROM feeding a single-cycle MIPS subset core.
module mips_processor #(
    parameter int          IMEM_WORDS = 64,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset
);
    logic [$clog2(IMEM_WORDS)-1:0] fetch_idx;
    logic [31:0]                   instr;

    mips_imem #(.IMEM_WORDS(IMEM_WORDS)) imem (.idx(fetch_idx), .instr(instr));

    mips_core #(
        .IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS), .RESET_PC(RESET_PC)
    ) mips (
        .clk(clk), .reset(reset), .instr(instr), .fetch_idx(fetch_idx)
    );
endmodule

// File: tb/tb_mips_processor.sv
// Directed programs for the MIPS subset; expected architectural state is queued, then compared after each run.
module tb_mips_processor;

    localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08;
    localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18, F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_AND = 6'h24;
    localparam logic [5:0] F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
    localparam int SEL_PC = 32, SEL_HI = 33, SEL_LO = 34, SEL_MEM = 100;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    exp_t        sb[$];
    logic [31:0] prog[$];
    int          errors = 0;
    int          checks = 0;

    mips_processor dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                          logic [4:0] rd, logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] tgt);
        return {op, tgt};
    endfunction

    function automatic logic [31:0] observe(int sel);
        logic [4:0] r;
        logic [5:0] m;
        r = sel[4:0];
        m = 6'(sel - SEL_MEM);
        if (sel < 32)           return dut.mips.dp.gpr.registers[r];
        else if (sel == SEL_PC) return dut.mips.dp.pc_q;
        else if (sel == SEL_HI) return dut.mips.dp.hi_q;
        else if (sel == SEL_LO) return dut.mips.dp.lo_q;
        else                    return dut.mips.dp.dmem[m];
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.value) else begin
                errors++;
                $error("FAIL %s: observed=0x%08h expected=0x%08h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic load_rom();
        for (int i = 0; i < 64; i++) begin
            dut.imem.INSTRROM[i[5:0]] = (i < prog.size()) ? prog[i] : 32'h0;
        end
    endtask

    task automatic clear_gpr();
        for (int i = 0; i < 32; i++) dut.mips.dp.gpr.registers[i[4:0]] = 32'h0;
    endtask

    task automatic restart();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] fa, fb, ft, fi;
        logic [31:0] a, b;

        // Reset state
        clear_gpr();
        for (int i = 0; i < 64; i++) dut.mips.dp.dmem[i[5:0]] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_val("reset_pc", SEL_PC, 32'h0);
        expect_val("reset_hi", SEL_HI, 32'h0);
        expect_val("reset_lo", SEL_LO, 32'h0);
        check();

        // lui/ori/addi with negative immediate
        prog = '{enc_i(OP_LUI, 0, 1, 16'h1234), enc_i(OP_ORI, 1, 1, 16'h5678), enc_i(OP_ADDI, 0, 2, 16'hFFFF)};
        load_rom(); clear_gpr(); restart();
        expect_val("lui_ori", 1, 32'h1234_5678);
        expect_val("addi_neg", 2, 32'hFFFF_FFFF);
        expect_val("pc_after3", SEL_PC, 32'h0000_000C);
        run(3);
        check();

        // jal / jr subroutine
        prog = '{enc_j(OP_JAL, 26'd3), enc_i(OP_ADDI, 0, 5, 16'd1), enc_j(OP_J, 26'd2),
                 enc_i(OP_ADDI, 0, 4, 16'd5), enc_r(F_JR, 31, 0, 0, 0)};
        load_rom(); clear_gpr(); restart();
        expect_val("jal_link", 31, 32'h0000_0004);
        expect_val("sub_body", 4, 32'd5);
        expect_val("after_return", 5, 32'd1);
        expect_val("pc_jal_jr", SEL_PC, 32'h0000_0008);
        run(4);
        check();

        // beq taken, bne not taken, bne taken
        prog = '{enc_i(OP_ADDI, 0, 1, 16'd3), enc_i(OP_ADDI, 0, 2, 16'd3), enc_i(OP_BEQ, 1, 2, 16'd1),
                 enc_i(OP_ADDI, 0, 3, 16'd9), enc_i(OP_BNE, 1, 2, 16'd1), enc_i(OP_ADDI, 0, 6, 16'd7),
                 enc_i(OP_BNE, 1, 0, 16'd1), enc_i(OP_ADDI, 0, 8, 16'd1), enc_i(OP_ADDI, 0, 9, 16'd2)};
        load_rom(); clear_gpr(); restart();
        expect_val("beq_skip", 3, 32'h0);
        expect_val("bne_fall", 6, 32'd7);
        expect_val("bne_skip", 8, 32'h0);
        expect_val("bne_target", 9, 32'd2);
        expect_val("pc_branch", SEL_PC, 32'h0000_0024);
        run(7);
        check();

        // multu / mult / mfhi / mflo
        prog = '{enc_r(F_MULTU, 1, 2, 0, 0), enc_r(F_MFLO, 0, 0, 3, 0), enc_r(F_MFHI, 0, 0, 4, 0),
                 enc_r(F_MULT, 5, 6, 0, 0), enc_r(F_MFHI, 0, 0, 7, 0), enc_r(F_MFLO, 0, 0, 8, 0),
                 enc_r(F_MULTU, 5, 6, 0, 0)};
        load_rom(); clear_gpr();
        dut.mips.dp.gpr.registers[1] = 32'd7;
        dut.mips.dp.gpr.registers[2] = 32'd6;
        dut.mips.dp.gpr.registers[5] = 32'hFFFF_FFFF;
        dut.mips.dp.gpr.registers[6] = 32'd2;
        restart();
        expect_val("multu_lo", 3, 32'd42);
        expect_val("multu_hi", 4, 32'd0);
        expect_val("mult_hi_reg", 7, 32'hFFFF_FFFF);
        expect_val("mult_lo_reg", 8, 32'hFFFF_FFFE);
        expect_val("mult_hi", SEL_HI, 32'hFFFF_FFFF);
        expect_val("mult_lo", SEL_LO, 32'hFFFF_FFFE);
        run(6);
        check();
        expect_val("multu_big_hi", SEL_HI, 32'h0000_0001);
        expect_val("multu_big_lo", SEL_LO, 32'hFFFF_FFFE);
        run(1);
        check();

        // Fibonacci loop, 29 commits
        prog = '{enc_i(OP_ADDI, 0, 1, 16'd0), enc_i(OP_ADDI, 0, 2, 16'd1), enc_i(OP_ADDI, 0, 3, 16'd10),
                 enc_i(OP_ADDI, 0, 4, 16'd0), enc_i(OP_BEQ, 4, 3, 16'd5), enc_r(F_ADD, 1, 2, 5, 0),
                 enc_r(F_ADD, 2, 0, 1, 0), enc_r(F_ADD, 5, 0, 2, 0), enc_i(OP_ADDI, 4, 4, 16'd1),
                 enc_j(OP_J, 26'd4), enc_j(OP_J, 26'd10)};
        load_rom(); clear_gpr(); restart();
        expect_val("hilo_rereset_hi", SEL_HI, 32'h0);
        expect_val("hilo_rereset_lo", SEL_LO, 32'h0);
        check();
        fa = 0; fb = 1; ft = 0; fi = 0;
        for (int k = 0; k < (29 - 4) / 6; k++) begin
            ft = fa + fb; fa = fb; fb = ft; fi++;
        end
        expect_val("fib_a", 1, fa);
        expect_val("fib_b", 2, fb);
        expect_val("fib_limit", 3, 32'd10);
        expect_val("fib_count", 4, fi);
        expect_val("fib_tmp", 5, ft);
        expect_val("fib_pc", SEL_PC, 32'h0000_0014);
        run(29);
        check();
        for (int i = 1; i < 32; i++) begin
            checks++;
            assert (!$isunknown(dut.mips.dp.gpr.registers[i[4:0]])) else begin
                errors++;
                $error("FAIL gpr_x_free: observed=$%0d=0x%08h expected=known value", i, dut.mips.dp.gpr.registers[i[4:0]]);
            end
        end

        // Writes to $0 are discarded and $0 reads as zero
        prog = '{enc_i(OP_ADDI, 0, 0, 16'd5), enc_r(F_ADD, 1, 1, 0, 0), enc_i(OP_ADDI, 0, 9, 16'd1),
                 enc_i(OP_LUI, 0, 0, 16'hFFFF)};
        load_rom(); clear_gpr();
        dut.mips.dp.gpr.registers[1] = 32'd3;
        restart();
        expect_val("zero_reg", 0, 32'h0);
        expect_val("zero_read", 9, 32'd1);
        run(4);
        check();

        // Reset mid-loop: PC returns to 0 and the reset edge commits no write
        prog = '{enc_i(OP_ADDI, 0, 1, 16'd0), enc_i(OP_ADDI, 0, 2, 16'd1), enc_i(OP_ADDI, 0, 3, 16'd10),
                 enc_i(OP_ADDI, 0, 4, 16'd0), enc_i(OP_BEQ, 4, 3, 16'd5), enc_r(F_ADD, 1, 2, 5, 0),
                 enc_r(F_ADD, 2, 0, 1, 0), enc_r(F_ADD, 5, 0, 2, 0), enc_i(OP_ADDI, 4, 4, 16'd1),
                 enc_j(OP_J, 26'd4), enc_j(OP_J, 26'd10)};
        load_rom(); clear_gpr(); restart();
        expect_val("pre_reset_pc", SEL_PC, 32'h0000_0014);
        run(11);
        check();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        expect_val("midreset_pc", SEL_PC, 32'h0);
        expect_val("midreset_no_wr", 5, 32'd1);
        expect_val("midreset_r1", 1, 32'd1);
        expect_val("midreset_r2", 2, 32'd1);
        expect_val("midreset_r4", 4, 32'd1);
        check();
        expect_val("restart_exec", 1, 32'd0);
        expect_val("restart_pc", SEL_PC, 32'h0000_0004);
        run(1);
        check();

        // sw then lw from the same address, plus lw with negative offset
        prog = '{enc_i(OP_ADDI, 0, 1, 16'h0040), enc_i(OP_LUI, 0, 2, 16'hDEAD), enc_i(OP_ORI, 2, 2, 16'hBEEF),
                 enc_i(OP_SW, 1, 2, 16'd4), enc_i(OP_LW, 1, 3, 16'd4), enc_i(OP_LW, 1, 4, 16'hFFFC)};
        load_rom(); clear_gpr();
        dut.mips.dp.dmem[15] = 32'hCAFE_F00D;
        restart();
        expect_val("sw_mem", SEL_MEM + 17, 32'hDEAD_BEEF);
        expect_val("lw_same", 3, 32'hDEAD_BEEF);
        expect_val("lw_negoff", 4, 32'hCAFE_F00D);
        run(6);
        check();

        // ALU operations, immediate extension and unlisted encodings
        a = 32'h8000_0003;
        b = 32'h0000_0005;
        prog = '{enc_r(F_SUB, 1, 2, 3, 0), enc_r(F_AND, 1, 2, 4, 0), enc_r(F_OR, 1, 2, 5, 0),
                 enc_r(F_XOR, 1, 2, 6, 0), enc_r(F_NOR, 1, 2, 7, 0), enc_r(F_SLT, 1, 2, 8, 0),
                 enc_r(F_SLTU, 1, 2, 9, 0), enc_r(F_SLL, 0, 2, 10, 4), enc_r(F_SRA, 0, 1, 11, 1),
                 enc_r(F_SRL, 0, 1, 12, 1), enc_i(OP_SLTIU, 2, 13, 16'hFFFF), enc_i(OP_SLTI, 2, 14, 16'hFFFF),
                 enc_i(OP_ANDI, 1, 15, 16'hFFFF), enc_i(OP_XORI, 2, 16, 16'h8000), enc_r(F_ADDU, 1, 1, 17, 0),
                 enc_i(6'h3F, 0, 18, 16'h1234), enc_r(6'h3F, 1, 2, 19, 0)};
        load_rom(); clear_gpr();
        dut.mips.dp.gpr.registers[1] = a;
        dut.mips.dp.gpr.registers[2] = b;
        restart();
        expect_val("alu_sub", 3, a - b);
        expect_val("alu_and", 4, a & b);
        expect_val("alu_or", 5, a | b);
        expect_val("alu_xor", 6, a ^ b);
        expect_val("alu_nor", 7, ~(a | b));
        expect_val("alu_slt", 8, 32'd1);
        expect_val("alu_sltu", 9, 32'd0);
        expect_val("alu_sll", 10, b << 4);
        expect_val("alu_sra", 11, 32'hC000_0001);
        expect_val("alu_srl", 12, a >> 1);
        expect_val("alu_sltiu", 13, 32'd1);
        expect_val("alu_slti", 14, 32'd0);
        expect_val("alu_andi", 15, a & 32'h0000_FFFF);
        expect_val("alu_xori", 16, b ^ 32'h0000_8000);
        expect_val("alu_addu_wrap", 17, a + a);
        expect_val("nop_opcode", 18, 32'h0);
        expect_val("nop_funct", 19, 32'h0);
        expect_val("alu_pc", SEL_PC, 32'h0000_0044);
        run(17);
        check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
